// File: rtl/intra_filt_pkg.sv
// Shared constants and helpers for the intra-angular filter accumulation stage.
// Optional clip flag output is enabled with `define INTRA_FILT_CLIP_FLAG_EN.
package intra_filt_pkg;

  localparam int ROUND_OFF  = 32;
  localparam int FILT_SHIFT = 6;

  // Accumulator width for the default 16-bit tap products (four products summed).
  localparam int PROD_W_DEFAULT = 16;
  localparam int ACC_W          = PROD_W_DEFAULT + 2;
  typedef logic signed [ACC_W-1:0] acc_t;

  // Saturate a signed value to the unsigned pixel range [0, 2^bit_depth-1].
  function automatic logic [31:0] clip_pix(input logic signed [31:0] value,
                                           input int bit_depth);
    logic signed [31:0] maxVal;
    maxVal = (32'sd1 <<< bit_depth) - 32'sd1;
    if (value < 0) begin
      return '0;
    end else if (value > maxVal) begin
      return maxVal;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/intra_filt_clip.sv
// Combinational round, arithmetic shift and pixel clip of one accumulated sample.
// Drives clipped_o only when INTRA_FILT_CLIP_FLAG_EN is defined.
module intra_filt_clip
  import intra_filt_pkg::*;
#(
  parameter int SUM_W     = 18,
  parameter int BIT_DEPTH = 8
) (
  input  logic signed [SUM_W-1:0]     sum_i,
  output logic        [BIT_DEPTH-1:0] sample_o
`ifdef INTRA_FILT_CLIP_FLAG_EN
  ,
  output logic                        clipped_o
`endif
);

  // One guard bit: adding the rounding offset to the largest sum would overflow SUM_W.
  localparam int RW = SUM_W + 1;

  logic signed [RW-1:0] rounded;
  logic signed [31:0]   rExt;

  assign rounded  = (RW'(sum_i) + RW'(ROUND_OFF)) >>> FILT_SHIFT;
  assign rExt     = 32'(rounded);
  assign sample_o = BIT_DEPTH'(clip_pix(rExt, BIT_DEPTH));

`ifdef INTRA_FILT_CLIP_FLAG_EN
  localparam logic signed [31:0] MAX_PIX = (32'sd1 <<< BIT_DEPTH) - 32'sd1;

  assign clipped_o = (rExt < 0) || (rExt > MAX_PIX);
`endif

endmodule

// File: rtl/intra_filt_accum.sv
// Two-stage accumulate/round/clip pipeline with valid/ready flow control and block index.
// Defining INTRA_FILT_CLIP_FLAG_EN adds the registered out_clipped port.
module intra_filt_accum
  import intra_filt_pkg::*;
#(
  parameter int BIT_DEPTH     = 8,
  parameter int PROD_W        = 16,
  parameter int BLOCK_SAMPLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [PROD_W-1:0]         in_p0,
  input  logic signed [PROD_W-1:0]         in_p1,
  input  logic signed [PROD_W-1:0]         in_p2,
  input  logic signed [PROD_W-1:0]         in_p3,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [BIT_DEPTH-1:0]             out_sample,
  output logic [$clog2(BLOCK_SAMPLES)-1:0] out_idx,
  output logic                             out_last
`ifdef INTRA_FILT_CLIP_FLAG_EN
  ,
  output logic                             out_clipped
`endif
);

  localparam int S1_W  = PROD_W + 1;
  localparam int SUM_W = PROD_W + 2;
  localparam int IDX_W = $clog2(BLOCK_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SAMPLES - 1);

  logic                    adv;
  logic                    drain;
  logic signed [S1_W-1:0]  s1_a_q, s1_a_d;
  logic signed [S1_W-1:0]  s1_b_q, s1_b_d;
  logic                    s1_v_q, s1_v_d;
  logic signed [SUM_W-1:0] sum;
  logic [BIT_DEPTH-1:0]    clipSample;
  logic [BIT_DEPTH-1:0]    out_sample_q, out_sample_d;
  logic                    out_valid_q, out_valid_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  // Whole pipeline moves as one; a stalled output freezes both stages.
  assign adv      = !out_valid_q || out_ready;
  assign drain    = out_valid_q && out_ready;
  assign in_ready = adv;

  assign sum = SUM_W'(s1_a_q) + SUM_W'(s1_b_q);

`ifdef INTRA_FILT_CLIP_FLAG_EN
  logic clipFlag;
  logic clipped_q, clipped_d;

  intra_filt_clip #(
    .SUM_W    (SUM_W),
    .BIT_DEPTH(BIT_DEPTH)
  ) u_clip (
    .sum_i    (sum),
    .sample_o (clipSample),
    .clipped_o(clipFlag)
  );
`else
  intra_filt_clip #(
    .SUM_W    (SUM_W),
    .BIT_DEPTH(BIT_DEPTH)
  ) u_clip (
    .sum_i   (sum),
    .sample_o(clipSample)
  );
`endif

  always_comb begin
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_v_d       = s1_v_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;
    if (adv) begin
      s1_a_d       = S1_W'(in_p0) + S1_W'(in_p1);
      s1_b_d       = S1_W'(in_p2) + S1_W'(in_p3);
      s1_v_d       = in_valid;
      out_sample_d = clipSample;
      out_valid_d  = s1_v_q;
    end
  end

  // Sample index advances only on a completed output handshake.
  always_comb begin
    idx_d = idx_q;
    if (drain) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_v_q       <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      idx_q        <= '0;
    end else begin
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_v_q       <= s1_v_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      idx_q        <= idx_d;
    end
  end

`ifdef INTRA_FILT_CLIP_FLAG_EN
  always_comb begin
    clipped_d = clipped_q;
    if (adv) begin
      clipped_d = clipFlag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clipped_q <= 1'b0;
    end else begin
      clipped_q <= clipped_d;
    end
  end

  assign out_clipped = clipped_q;
`endif

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_idx    = idx_q;
  assign out_last   = out_valid_q && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_intra_filt_accum.sv
// Directed, table-driven bench for intra_filt_accum (default parameters).
// Also checks out_clipped when INTRA_FILT_CLIP_FLAG_EN is defined.
module tb_intra_filt_accum;

  typedef struct {
    logic signed [15:0] p0;
    logic signed [15:0] p1;
    logic signed [15:0] p2;
    logic signed [15:0] p3;
    int                 expSample;
    int                 expClip;
  } vec_t;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] p0, p1, p2, p3;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_sample;
  logic [3:0]         out_idx;
  logic               out_last;
`ifdef INTRA_FILT_CLIP_FLAG_EN
  logic               out_clipped;
`endif

  int   nTests;
  int   nFail;
  int   expIdx;
  vec_t vecs[12];
  int   bpIn[4];
  int   bpExp[4];

  intra_filt_accum #(
    .BIT_DEPTH    (8),
    .PROD_W       (16),
    .BLOCK_SAMPLES(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_p0      (p0),
    .in_p1      (p1),
    .in_p2      (p2),
    .in_p3      (p3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample),
    .out_idx    (out_idx),
    .out_last   (out_last)
`ifdef INTRA_FILT_CLIP_FLAG_EN
    ,
    .out_clipped(out_clipped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nTests++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a negedge: presents one transaction for a single cycle.
  task automatic applyStimulus(input logic signed [15:0] a, input logic signed [15:0] b,
                               input logic signed [15:0] c, input logic signed [15:0] d);
    in_valid = 1'b1;
    p0 = a;
    p1 = b;
    p2 = c;
    p3 = d;
    @(negedge clk);
    in_valid = 1'b0;
    p0 = '0;
    p1 = '0;
    p2 = '0;
    p3 = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int sent;
    int got;
    int stallLeft;
    int lastCount;

    nTests    = 0;
    nFail     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    p0 = '0;
    p1 = '0;
    p2 = '0;
    p3 = '0;

    vecs[0]  = '{16'sd1600,   16'sd5100,   16'sd1900,   16'sd2700,   177, 0};
    vecs[1]  = '{16'sd16000,  16'sd16000,  16'sd16000,  16'sd16000,  255, 1};
    vecs[2]  = '{-16'sd2000,  16'sd0,      16'sd0,      16'sd0,      0,   1};
    vecs[3]  = '{-16'sd32,    16'sd0,      16'sd0,      16'sd0,      0,   0};
    vecs[4]  = '{-16'sd33,    16'sd0,      16'sd0,      16'sd0,      0,   1};
    vecs[5]  = '{16'sd16288,  16'sd0,      16'sd0,      16'sd0,      255, 0};
    vecs[6]  = '{16'sd16352,  16'sd0,      16'sd0,      16'sd0,      255, 1};
    vecs[7]  = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 0,   1};
    vecs[8]  = '{16'sd32767,  16'sd32767,  16'sd32767,  16'sd32767,  255, 1};
    vecs[9]  = '{16'sd3000,   -16'sd1000,  16'sd500,    -16'sd200,   36,  0};
    vecs[10] = '{16'sd31,     16'sd0,      16'sd0,      16'sd0,      0,   0};
    vecs[11] = '{16'sd32,     16'sd0,      16'sd0,      16'sd0,      1,   0};

    bpIn  = '{11300, 2300, 32, 16288};
    bpExp = '{177,   36,   1,  255};

    doReset();
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_sample", int'(out_sample), 0);
    checkOutput("reset_out_idx", int'(out_idx), 0);
    checkOutput("reset_out_last", int'(out_last), 0);
    checkOutput("reset_in_ready", int'(in_ready), 1);
    expIdx = 0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      checkOutput($sformatf("vec%0d_sample", i), int'(out_sample), vecs[i].expSample);
      checkOutput($sformatf("vec%0d_idx", i), int'(out_idx), expIdx);
      checkOutput($sformatf("vec%0d_last", i), int'(out_last), 0);
`ifdef INTRA_FILT_CLIP_FLAG_EN
      checkOutput($sformatf("vec%0d_clip", i), int'(out_clipped), vecs[i].expClip);
`endif
      expIdx = (expIdx + 1) % 16;
    end

    // Mid-stream reset with two samples in flight and a nonzero index.
    @(negedge clk);
    in_valid = 1'b1;
    p0 = 16'sd640;
    @(negedge clk);
    p0 = 16'sd1280;
    @(negedge clk);
    in_valid = 1'b0;
    p0 = '0;
    checkOutput("mid_pre_valid", int'(out_valid), 1);
    checkOutput("mid_pre_idx", int'(out_idx), expIdx);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid_rst_valid", int'(out_valid), 0);
    checkOutput("mid_rst_idx", int'(out_idx), 0);
    checkOutput("mid_rst_last", int'(out_last), 0);
    @(negedge clk);
    checkOutput("mid_flushed_valid", int'(out_valid), 0);
    applyStimulus(16'sd448, 16'sd0, 16'sd0, 16'sd0);
    @(negedge clk);
    checkOutput("mid_next_valid", int'(out_valid), 1);
    checkOutput("mid_next_sample", int'(out_sample), 7);
    checkOutput("mid_next_idx", int'(out_idx), 0);
    expIdx = 1;

    // Backpressure: four back-to-back inputs, 3-cycle stall after the first output.
    @(negedge clk);
    sent      = 0;
    got       = 0;
    stallLeft = -1;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      if (out_valid && stallLeft < 0) stallLeft = 3;
      out_ready = !(stallLeft > 0);
      in_valid  = (sent < 4);
      if (sent < 4) p0 = 16'(bpIn[sent]);
      else p0 = '0;
      #1;
      if (out_valid && !out_ready) begin
        checkOutput("bp_stall_in_ready", int'(in_ready), 0);
        checkOutput("bp_stall_sample", int'(out_sample), bpExp[got]);
        checkOutput("bp_stall_idx", int'(out_idx), expIdx);
      end
      if (out_valid && out_ready) begin
        checkOutput($sformatf("bp_out%0d_sample", got), int'(out_sample), bpExp[got]);
        checkOutput($sformatf("bp_out%0d_idx", got), int'(out_idx), expIdx);
        got++;
        expIdx = (expIdx + 1) % 16;
      end
      if (in_valid && in_ready) sent++;
      if (stallLeft > 0) stallLeft--;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    p0        = '0;
    out_ready = 1'b1;
    checkOutput("bp_delivered", got, 4);
    checkOutput("bp_stalled", stallLeft, 0);

    // Block wrap: 32 outputs from a clean reset, sample value k for k-th input.
    doReset();
    expIdx    = 0;
    sent      = 0;
    got       = 0;
    lastCount = 0;
    for (int cyc = 0; cyc < 200 && got < 32; cyc++) begin
      in_valid = (sent < 32);
      p0 = (sent < 32) ? 16'(sent * 64) : '0;
      #1;
      if (out_valid) begin
        checkOutput($sformatf("wrap%0d_sample", got), int'(out_sample), got);
        checkOutput($sformatf("wrap%0d_idx", got), int'(out_idx), expIdx);
        checkOutput($sformatf("wrap%0d_last", got), int'(out_last), (expIdx == 15) ? 1 : 0);
        if (out_last) lastCount++;
        got++;
        expIdx = (expIdx + 1) % 16;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    p0       = '0;
    checkOutput("wrap_delivered", got, 32);
    checkOutput("wrap_last_count", lastCount, 2);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
